// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the dual-port SRAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;
    localparam int CPU_ADDR_W = 16;
    localparam int RD_LAT     = 3;
    localparam int WR_LAT     = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_STROBE = 3'd1,
        RD_SAMPLE = 3'd2,
        WR_SETUP  = 3'd3,
        WR_PULSE  = 3'd4,
        WR_HOLD   = 3'd5
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [CPU_ADDR_W-1:0] addr;
    } arb_req_t;

endpackage

// File: rtl/sram_if_drv.sv
// SRAM pin driver: registered active-low strobes and the tristate data bus.
module sram_if_drv
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_on,
    input  logic              wr_on,
    input  logic              en_on,
    input  logic              oe_on,
    input  logic              wdata_ld,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] bus_rd,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic              memRead,
    output logic              memWrite,
    output logic              memEnable
);

    logic              oe;
    logic [DATA_W-1:0] wdata_q;

    // Strobes are registered from the next-state decode so pins switch cleanly on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            memRead   <= 1'b1;
            memWrite  <= 1'b1;
            memEnable <= 1'b1;
            oe        <= 1'b0;
        end else begin
            memRead   <= !rd_on;
            memWrite  <= !wr_on;
            memEnable <= !en_on;
            oe        <= oe_on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           wdata_q <= '0;
        else if (wdata_ld) wdata_q <= wdata;
    end

    assign dataBus = oe ? wdata_q : 'z;
    assign bus_rd  = dataBus;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one async SRAM.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on conflict; default favours data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [CPU_ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [CPU_ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_ready,
    output logic [ADDR_W-1:0]     addrBus,
    inout  wire  [DATA_W-1:0]     dataBus,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  memEnable
);

    arb_state_t        state, state_nxt;
    arb_req_t          win;
    logic              grant_dm, grant_any, load;
    logic              cur_dm;
    logic              rd_on, wr_on, en_on, oe_on;
    logic [DATA_W-1:0] bus_rd;

    assign grant_any = if_req || dm_req;
    assign load      = (state == IDLE) && grant_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_if;

    // Starts as "fetch" so the first conflict after reset goes to data.
    always_ff @(posedge clk) begin
        if (rst)       last_if <= 1'b1;
        else if (load) last_if <= !grant_dm;
    end

    assign grant_dm = dm_req && (!if_req || last_if);
`else
    assign grant_dm = dm_req;
`endif

    always_comb begin
        win = '{we: 1'b0, addr: if_addr};
        if (grant_dm) win = '{we: dm_we, addr: dm_addr};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_any) state_nxt = win.we ? WR_SETUP : RD_STROBE;
            RD_STROBE: state_nxt = RD_SAMPLE;
            RD_SAMPLE: state_nxt = IDLE;
            WR_SETUP:  state_nxt = WR_PULSE;
            WR_PULSE:  state_nxt = WR_HOLD;
            WR_HOLD:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_on = 1'b0;
        wr_on = 1'b0;
        en_on = 1'b0;
        oe_on = 1'b0;
        case (state_nxt)
            RD_STROBE, RD_SAMPLE: begin rd_on = 1'b1; en_on = 1'b1; end
            WR_SETUP, WR_HOLD:    begin oe_on = 1'b1; en_on = 1'b1; end
            WR_PULSE:             begin oe_on = 1'b1; en_on = 1'b1; wr_on = 1'b1; end
            default: ;
        endcase
    end

    // addrBus only changes at a grant, so it stays put for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            addrBus  <= '0;
            cur_dm   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (load) begin
                cur_dm  <= grant_dm;
                addrBus <= ADDR_W'(win.addr);
            end
            if (state == RD_SAMPLE) begin
                if (cur_dm) begin dm_rdata <= bus_rd; dm_ready <= 1'b1; end
                else        begin if_rdata <= bus_rd; if_ready <= 1'b1; end
            end
            if (state == WR_HOLD) dm_ready <= 1'b1;
        end
    end

    sram_if_drv #(.DATA_W(DATA_W)) u_drv (
        .clk       (clk),
        .rst       (rst),
        .rd_on     (rd_on),
        .wr_on     (wr_on),
        .en_on     (en_on),
        .oe_on     (oe_on),
        .wdata_ld  (load),
        .wdata     (dm_wdata),
        .bus_rd    (bus_rd),
        .dataBus   (dataBus),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .memEnable (memEnable)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences, randomized scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata;
    logic        if_ready, dm_ready;
    logic [17:0] addrBus;
    wire  [15:0] dataBus;
    logic        memRead, memWrite, memEnable;
    logic        probe;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int both_low = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(18), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .addrBus(addrBus), .dataBus(dataBus),
        .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable)
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    // Async SRAM model; probe pulls the bus to 0 to expose a DUT that fails to release it.
    logic [15:0] mem [0:65535];
    logic        mem_init = 1'b0;
    wire         sram_oe = !memEnable && !memRead;
    assign dataBus = (sram_oe || probe) ? (sram_oe ? mem[addrBus[15:0]] : 16'h0000) : 16'hzzzz;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
            mem_init <= 1'b1;
        end else if (!memEnable && !memWrite) begin
            mem[addrBus[15:0]] <= dataBus;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!memRead && !memWrite) both_low <= both_low + 1;

    // Reference model: a single server, busy 3 cycles per read and 4 per write.
    logic        rnd_on = 1'b0;
    logic [15:0] shadow [0:65535];
    logic        sh_init = 1'b0;
    int          m_free, exp_if_at, exp_dm_at;
    logic [15:0] exp_if_d, exp_dm_d;
    logic        exp_dm_rd, m_last_if;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    wire         m_pref_dm = m_last_if;
    localparam logic [2:0] CONFLICT_SEQ = 3'b101;
`else
    wire         m_pref_dm = 1'b1;
    localparam logic [2:0] CONFLICT_SEQ = 3'b111;
`endif
    wire         m_take_dm = dm_req && (!if_req || m_pref_dm);

    always @(posedge clk) begin
        if (!sh_init) begin
            for (int i = 0; i < 65536; i++) shadow[i] <= pat(16'(i));
            sh_init <= 1'b1;
        end
        if (rst) begin
            m_free    <= 0;
            m_last_if <= 1'b1;
            exp_if_at <= 0;
            exp_dm_at <= 0;
            exp_dm_rd <= 1'b0;
        end else if (rnd_on && cyc >= m_free && (if_req || dm_req)) begin
            m_last_if <= !m_take_dm;
            if (m_take_dm) begin
                m_free    <= cyc + (dm_we ? 4 : 3);
                exp_dm_at <= cyc + (dm_we ? 4 : 3);
                exp_dm_rd <= !dm_we;
                exp_dm_d  <= shadow[dm_addr];
                if (dm_we) shadow[dm_addr] <= dm_wdata;
            end else begin
                m_free    <= cyc + 3;
                exp_if_at <= cyc + 3;
                exp_if_d  <= shadow[if_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One isolated transaction; req is held for the grant cycle only.
    task automatic run_txn(input string nm, input logic dm, input logic we,
                           input logic [15:0] a, input logic [15:0] wd, input logic [15:0] exp_rd);
        int rdy_at = 0, nrdy = 0, other = 0, rd_lo = 0, wr_lo = 0, en_lo = 0, drv = 0;
        logic [15:0] got = '0;
        logic [17:0] ab = '0;
        @(negedge clk);
        if (dm) begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
        else    begin if_req = 1'b1; if_addr = a; end
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin if_req = 1'b0; dm_req = 1'b0; ab = addrBus; end
            if (!memRead)   rd_lo++;
            if (!memWrite)  wr_lo++;
            if (!memEnable) en_lo++;
            if (!memEnable && memRead && dataBus == wd) drv++;
            if (dm ? dm_ready : if_ready) begin nrdy++; rdy_at = k; got = dm ? dm_rdata : if_rdata; end
            if (dm ? if_ready : dm_ready) other++;
        end
        chk({nm, "_addr"},   32'(ab), {14'd0, 2'b00, a});
        chk({nm, "_rdy_at"}, rdy_at, we ? 4 : 3);
        chk({nm, "_nrdy"},   nrdy, 1);
        chk({nm, "_other"},  other, 0);
        chk({nm, "_rd_lo"},  rd_lo, we ? 0 : 2);
        chk({nm, "_wr_lo"},  wr_lo, we ? 1 : 0);
        chk({nm, "_en_lo"},  en_lo, we ? 3 : 2);
        chk({nm, "_drv"},    drv, we ? 3 : 0);
        if (we) chk({nm, "_mem"}, 32'(mem[a]), 32'(wd));
        else    chk({nm, "_rdata"}, 32'(got), 32'(exp_rd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        dm;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        logic [15:0] last_if = '0, last_dm = '0;
        logic [2:0]  exp_seq;
        logic [2:0]  seq;
        int          ng, nrdy, k6;
        logic [17:0] ab1, ab2;
        logic [15:0] d1, d2;

        rst = 1'b1; probe = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memRead", 32'(memRead), 1);
        chk("rst_memWrite", 32'(memWrite), 1);
        chk("rst_memEnable", 32'(memEnable), 1);
        chk("rst_addrBus", 32'(addrBus), 0);
        chk("rst_ready", {30'd0, if_ready, dm_ready}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        probe = 1'b1; #1;
        chk("rst_bus_z", 32'(dataBus), 0);
        probe = 1'b0;
        rst = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'h5A5A, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h5A5A};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, pat(16'hFFFF)};
        vecs[4] = '{1'b1, 1'b1, 16'h4000, 16'h1357, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0003, 16'h0000, pat(16'h0003)};
        vecs[6] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'h1357};
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp);
            if (!vecs[i].we) begin
                if (vecs[i].dm) last_dm = vecs[i].exp;
                else            last_if = vecs[i].exp;
            end
            chk($sformatf("vec%0d_hold_if", i), 32'(if_rdata), 32'(last_if));
            chk($sformatf("vec%0d_hold_dm", i), 32'(dm_rdata), 32'(last_dm));
        end

        // Reset while the write pulse is on the pins.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h7777;
        @(posedge clk);
        @(negedge clk); dm_req = 1'b0;
        @(negedge clk);
        chk("rstwr_in_pulse", 32'(memWrite), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_memWrite", 32'(memWrite), 1);
        chk("rstwr_idle", 32'(memEnable), 1);
        chk("rstwr_dm_ready", 32'(dm_ready), 0);
        chk("rstwr_addrBus", 32'(addrBus), 0);
        chk("rstwr_rdata", {if_rdata, dm_rdata}, 0);
        probe = 1'b1; #1;
        chk("rstwr_bus_z", 32'(dataBus), 0);
        probe = 1'b0;
        rst = 1'b0;
        nrdy = 0; ng = 0;
        repeat (5) begin
            @(negedge clk);
            if (dm_ready) nrdy++;
            if (!memEnable || !memWrite) ng++;
        end
        chk("rstwr_no_ready", nrdy, 0);
        chk("rstwr_no_strobe", ng, 0);

        // Conflict: both ports request continuously, right after reset.
        exp_seq = CONFLICT_SEQ;
        seq = '0; ng = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0010; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
        for (int k = 0; k < 20 && ng < 3; k++) begin
            @(negedge clk);
            if (dm_ready) begin
                seq[ng] = 1'b1; ng++;
                chk("conf_dm_rdata", 32'(dm_rdata), 32'(pat(16'h0020)));
            end else if (if_ready) begin
                seq[ng] = 1'b0; ng++;
                chk("conf_if_rdata", 32'(if_rdata), 32'(pat(16'h0010)));
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("conf_count", ng, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("conf_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        repeat (6) @(negedge clk);

        // Back-to-back fetches at the address extremes.
        nrdy = 0; ab1 = '0; ab2 = '0; d1 = '0; d2 = '0; k6 = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'hFFFF;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) ab1 = addrBus;
            if (k == 4) ab2 = addrBus;
            if (if_ready) begin
                nrdy++;
                if (nrdy == 1) begin d1 = if_rdata; if_addr = 16'h0000; end
                else begin d2 = if_rdata; k6 = k; if_req = 1'b0; end
            end
        end
        chk("b2b_addr1", 32'(ab1), 32'h0FFFF);
        chk("b2b_addr2", 32'(ab2), 32'h00000);
        chk("b2b_nrdy", nrdy, 2);
        chk("b2b_second_at", k6, 6);
        chk("b2b_data1", 32'(d1), 32'(pat(16'hFFFF)));
        chk("b2b_data2", 32'(d2), 32'(pat(16'h0000)));

        // Randomized traffic against the reference model.
        do_reset();
        @(negedge clk);
        rnd_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_if_ready", 32'(if_ready), 32'(cyc == exp_if_at));
            chk("rnd_dm_ready", 32'(dm_ready), 32'(cyc == exp_dm_at));
            if (cyc == exp_if_at) chk("rnd_if_rdata", 32'(if_rdata), 32'(exp_if_d));
            if (cyc == exp_dm_at && exp_dm_rd) chk("rnd_dm_rdata", 32'(dm_rdata), 32'(exp_dm_d));
            if (if_req && if_ready) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            end
            if (dm_req && dm_ready) dm_req = 1'b0;
            else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
                dm_wdata = 16'($urandom);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (6) @(negedge clk);
        rnd_on = 1'b0;

        chk("never_both_strobes", both_low, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
